frame_bmp_streamer: RTL

- Read side of the frame buffer: once a frame has been written, scans the stored RGB frame and serialises it as a complete 24-bit BMP byte stream.
- Stream is the 54-byte header, then pixel rows bottom-up in B,G,R order, each row zero-padded to a 4-byte multiple.
- Output is a byte-wide valid/ready interface feeding the file/UART dump path.
- Frame buffer is accessed through a fixed-latency read port.

---
 rtl/frame_bmp_streamer.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/frame_bmp_streamer.sv
// frame_bmp_streamer
//   Read side of the frame buffer. After a start request it walks the stored
//   RGB frame and serialises it as a complete 24-bit BMP file: the 54-byte
//   header, then the pixel rows bottom-up in B,G,R order, each row zero-padded
//   to a multiple of 4 bytes.
//
// Ports
//   CAMERA_CLK        clock
//   rst               synchronous, active-high reset (aborts a dump at once)
//   start             request one frame dump (only looked at while idle)
//   rd_en             frame buffer read strobe, one cycle per pixel
//   rd_row / rd_col   pixel address presented with rd_en
//   rd_R/rd_G/rd_B    pixel data, valid RD_LAT cycles after rd_en
//   out_byte          stream byte
//   out_valid         out_byte is valid
//   out_ready         sink accepts the byte this cycle
//   busy              high from start acceptance until the dump finishes
//   done              one-cycle pulse after the final byte has been accepted
module frame_bmp_streamer #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int BMP_HEADER_NUM = 54,
  parameter int RD_LAT         = 1,
  parameter int COORD_W        = 11
) (
  input  logic               CAMERA_CLK,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_row,
  output logic [COORD_W-1:0] rd_col,
  input  logic [7:0]         rd_R,
  input  logic [7:0]         rd_G,
  input  logic [7:0]         rd_B,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int ROWBYTES  = ((WIDTH * 3 + 3) / 4) * 4;
  localparam int PAD_BYTES = ROWBYTES - WIDTH * 3;

  localparam logic [31:0] IMGSIZE  = 32'(ROWBYTES * HEIGHT);
  localparam logic [31:0] FILESIZE = 32'(BMP_HEADER_NUM) + IMGSIZE;

  localparam logic [5:0]         HDR_LAST  = 6'(BMP_HEADER_NUM - 1);
  localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_FIRST = COORD_W'(HEIGHT - 1);
  localparam logic [1:0]         PAD_LAST  = 2'(PAD_BYTES - 1);
  localparam logic [1:0]         LAT_LAST  = 2'(RD_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_WAIT,
    S_EMIT_B,
    S_EMIT_G,
    S_EMIT_R,
    S_PAD,
    S_DONE
  } state_t;

  state_t     state;
  logic [5:0] hdrIdx;
  logic [1:0] padCnt;
  logic [1:0] waitCnt;
  logic       xfer;
  logic       capture;

  // Green and red wait here while blue goes straight to out_byte.
  logic [7:0] pixG_p1;
  logic [7:0] pixR_p1;

  assign xfer    = out_valid && out_ready;
  assign capture = (state == S_WAIT) && (waitCnt == LAT_LAST);

  // Header byte at offset idx. Every field after 'BM' is a 32-bit word
  // starting at offset 2 (planes/bpp share one word), so the offset minus 2
  // splits cleanly into a word number and a byte lane.
  function automatic logic [7:0] headerByte(input logic [5:0] idx);
    logic [5:0]  off;
    logic [31:0] field;
    off = idx - 6'd2;
    case (off[5:2])
      4'd0:    field = FILESIZE;
      4'd2:    field = 32'(BMP_HEADER_NUM);
      4'd3:    field = 32'd40;
      4'd4:    field = 32'(WIDTH);
      4'd5:    field = 32'(HEIGHT);
      4'd6:    field = 32'h0018_0001;   // planes = 1, bpp = 24
      4'd8:    field = IMGSIZE;
      default: field = 32'd0;
    endcase
    if (idx == 6'd0)      headerByte = 8'h42;
    else if (idx == 6'd1) headerByte = 8'h4D;
    else                  headerByte = field[{off[1:0], 3'b000} +: 8];
  endfunction

  // ---- capture stage: pixel data arrives on the last WAIT cycle ----
  always_ff @(posedge CAMERA_CLK) begin
    if (capture) begin
      pixG_p1 <= rd_G;
      pixR_p1 <= rd_R;
    end
  end

  // rd_row / rd_col double as the scan position. The end-of-row decision is
  // taken in the same cycle as the last EMIT_R or PAD transfer, so there is
  // no separate row-end cycle.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_en     <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hdrIdx    <= '0;
      padCnt    <= '0;
      waitCnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_HEADER;
            busy      <= 1'b1;
            hdrIdx    <= '0;
            rd_row    <= ROW_FIRST;
            rd_col    <= '0;
            out_byte  <= headerByte(6'd0);
            out_valid <= 1'b1;
          end
        end

        S_HEADER: begin
          if (xfer) begin
            if (hdrIdx == HDR_LAST) begin
              state     <= S_FETCH;
              out_valid <= 1'b0;
              rd_en     <= 1'b1;
            end else begin
              hdrIdx   <= hdrIdx + 6'd1;
              out_byte <= headerByte(hdrIdx + 6'd1);
            end
          end
        end

        S_FETCH: begin
          rd_en   <= 1'b0;
          waitCnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          if (capture) begin
            out_byte  <= rd_B;
            out_valid <= 1'b1;
            state     <= S_EMIT_B;
          end else begin
            waitCnt <= waitCnt + 2'd1;
          end
        end

        S_EMIT_B: begin
          if (xfer) begin
            out_byte <= pixG_p1;
            state    <= S_EMIT_G;
          end
        end

        S_EMIT_G: begin
          if (xfer) begin
            out_byte <= pixR_p1;
            state    <= S_EMIT_R;
          end
        end

        S_EMIT_R: begin
          if (xfer) begin
            if (rd_col != COL_LAST) begin
              rd_col    <= rd_col + COORD_W'(1);
              rd_en     <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_FETCH;
            end else if (PAD_BYTES > 0) begin
              padCnt   <= '0;
              out_byte <= 8'h00;
              state    <= S_PAD;
            end else if (rd_row != '0) begin
              rd_row    <= rd_row - COORD_W'(1);
              rd_col    <= '0;
              rd_en     <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_FETCH;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_PAD: begin
          if (xfer) begin
            if (padCnt != PAD_LAST) begin
              padCnt <= padCnt + 2'd1;
            end else if (rd_row != '0) begin
              rd_row    <= rd_row - COORD_W'(1);
              rd_col    <= '0;
              rd_en     <= 1'b1;
              out_valid <= 1'b0;
              state     <= S_FETCH;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          rd_en     <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
